uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
Parameters:
REQ-001 NBIT_DATA, 8: data bits per frame; legal range 5..9.
REQ-002 NUM_TICKS, 16: tick pulses per bit period; legal range 8..32.
REQ-003 PARITY_MODE, 0: parity mode; 0 = none, 1 = even, 2 = odd.
REQ-004 STOP_BITS, 1: stop bits per frame; legal values 1 or 2.

Ports:
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 tick  in  1  baud-rate generator enable, one clk cycle wide per pulse.
REQ-008 tx_start  in  1  request to send data_in; level-sampled every clk cycle.
REQ-009 data_in  in  NBIT_DATA  word to transmit; sampled only on acceptance.
REQ-010 tx_bit  out  1  serial line, registered, idle high.
REQ-011 tx_done_tick  out  1  one-clk pulse marking end of frame.
REQ-012 tx_busy  out  1  high from acceptance until end of frame.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, and SHALL encode them in a 3-bit register.
REQ-014 In IDLE with tx_start=1, on that clk edge the block SHALL:
- latch data_in into the shift buffer;
- clear the tick and bit counters;
- enter START;
- set tx_busy=1.
This SHALL NOT depend on tick.
REQ-015 tx_bit SHALL be driven as follows, with each change taking effect on the same edge as the state change:
- START: 0.
- DATA: buffer[0], so bits go out LSB first.
- PARITY: parity bit.
- STOP: 1.
- IDLE: 1.
REQ-016 The tick counter SHALL advance only on clk edges where tick=1. A bit period SHALL end on the tick where the counter equals NUM_TICKS-1; that tick clears the counter.
REQ-017 At the end of START the FSM SHALL go to DATA.
REQ-018 At the end of each DATA bit the buffer SHALL shift right by one. After bit NBIT_DATA-1 the FSM SHALL go to PARITY if PARITY_MODE!=0, else to STOP.
REQ-019 The parity bit SHALL be XOR of the latched data for even parity, and its complement for odd parity. It SHALL be computed from the word as latched, not the shifted buffer.
REQ-020 STOP SHALL last STOP_BITS bit periods.
REQ-021 On the final stop tick the block SHALL:
- enter IDLE;
- pulse tx_done_tick=1 for exactly that one clk cycle;
- clear tx_busy on the same edge.
REQ-022 Frame duration SHALL be (1+NBIT_DATA+P+STOP_BITS)*NUM_TICKS tick pulses, where P=1 if parity is enabled, else 0.
REQ-023 tx_start while tx_busy=1 SHALL be ignored, including the tx_done_tick cycle. A new frame SHALL be accepted at the earliest one clk after tx_done_tick.
REQ-024 tx_start held high continuously SHALL produce back-to-back frames, each frame re-sampling data_in at its own acceptance.
REQ-025 Changes to data_in after acceptance SHALL NOT affect the frame in progress.
REQ-026 An unreachable state code SHALL return to IDLE on the next clk edge, with tx_bit=1 and counters cleared.
REQ-027 Bit and tick counters SHALL be $clog2-sized from the parameters and SHALL NOT wrap within a frame.

Reset
REQ-028 While reset=0, the block SHALL immediately hold:
- state=IDLE;
- tx_bit=1;
- tx_busy=0;
- tx_done_tick=0;
- counters and buffer cleared.
REQ-029 Reset asserted mid-frame SHALL abort the frame, drive tx_bit=1 without waiting for clk, and emit no tx_done_tick.
REQ-030 After reset deasserts, the first tx_start sampled on a clk edge SHALL be accepted normally.

Verification
REQ-031 8N1, NUM_TICKS=16, data_in=0xA5:
- line SHALL be 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks;
- tx_done_tick SHALL pulse once, on the 160th tick.
REQ-032 PARITY_MODE=1, data_in=0x07: parity bit SHALL be 1. With PARITY_MODE=2 the parity bit SHALL be 0, and the frame SHALL be 11 bit periods.
REQ-033 STOP_BITS=2, NBIT_DATA=7, data_in=0x55: line SHALL be high for 32 ticks after the last data bit, before tx_done_tick.
REQ-034 Second tx_start pulse with data_in=0xFF at tick 40 of a 0x00 frame: frame SHALL complete as 0x00 with no second frame started.
REQ-035 reset=0 at tick 70 of a frame: tx_bit SHALL be 1 and tx_busy 0 within the same cycle; no tx_done_tick.
REQ-036 tx_start held high with tick every clk: two consecutive frames SHALL be separated by exactly one clk of IDLE, with tx_done_tick pulsed twice.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Bit timing comes from an external tick enable; NUM_TICKS ticks make one bit period.
module uart_tx #(
  parameter int NBIT_DATA   = 8,
  parameter int NUM_TICKS   = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 tx_start,
  input  logic [NBIT_DATA-1:0] data_in,
  output logic                 tx_bit,
  output logic                 tx_done_tick,
  output logic                 tx_busy
);

  localparam int TICK_W = $clog2(NUM_TICKS);
  localparam int BIT_W  = $clog2(NBIT_DATA);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(NUM_TICKS - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(NBIT_DATA - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state;
  logic [TICK_W-1:0]      tick_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [NBIT_DATA-1:0]   buffer;
  logic                   parity_bit;
  logic                   bit_end;

  assign bit_end = tick && (tick_cnt == TICK_LAST);

  // NOTE: all state here is sequential and uses <=, so every branch reads the
  // pre-edge values (e.g. buffer[1] below is the next bit before the shift lands).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      buffer       <= '0;
      parity_bit   <= 1'b0;
      tx_bit       <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_busy      <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          tx_bit  <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            buffer     <= data_in;
            // Parity is taken from the word as accepted, never the shifting buffer.
            parity_bit <= (PARITY_MODE == 2) ? ~(^data_in) : ^data_in;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            state      <= START;
            tx_busy    <= 1'b1;
            tx_bit     <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            tick_cnt <= '0;
            state    <= DATA;
            tx_bit   <= buffer[0];
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            buffer   <= buffer >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_MODE != 0) begin
                state  <= PARITY;
                tx_bit <= parity_bit;
              end else begin
                state  <= STOP;
                tx_bit <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_bit  <= buffer[1];
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            tick_cnt <= '0;
            state    <= STOP;
            tx_bit   <= 1'b1;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        STOP: begin
          tx_bit <= 1'b1;
          if (bit_end) begin
            tick_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt      <= '0;
              state        <= IDLE;
              tx_done_tick <= 1'b1;
              tx_busy      <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          tx_bit   <= 1'b1;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations share clk/tick/reset; a frame-level
// model predicts the line per tick, plus directed literal checks of known frames.
module tb_uart_tx;

  localparam int N  = 4;
  localparam int NT = 16;
  localparam int P_NB [N] = '{8, 8, 8, 7};
  localparam int P_PM [N] = '{0, 1, 2, 0};
  localparam int P_SB [N] = '{1, 1, 1, 2};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       tx_start [N];
  logic [8:0] data_in  [N];
  logic       tx_bit   [N];
  logic       tx_done  [N];
  logic       tx_busy  [N];

  int checks   = 0;
  int failures = 0;
  int tick_div = 1;
  int tcnt     = 0;
  int done_cnt [N];

  always #5 clk = ~clk;

  // Tick enable derived from a free-running divider, changed away from posedge.
  always @(negedge clk) begin
    tcnt = tcnt + 1;
    tick = (tick_div <= 1) ? 1'b1 : ((tcnt % tick_div) == 0);
  end

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx #(
      .NBIT_DATA  (P_NB[g]),
      .NUM_TICKS  (NT),
      .PARITY_MODE(P_PM[g]),
      .STOP_BITS  (P_SB[g])
    ) u_dut (
      .clk         (clk),
      .reset       (rst_n),
      .tick        (tick),
      .tx_start    (tx_start[g]),
      .data_in     (data_in[g][P_NB[g]-1:0]),
      .tx_bit      (tx_bit[g]),
      .tx_done_tick(tx_done[g]),
      .tx_busy     (tx_busy[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: the line is the frame's bit list indexed by elapsed ticks / NT.
  logic m_bits  [N][16];
  bit   m_act   [N];
  int   m_ticks [N];
  int   m_total [N];
  logic e_bit   [N];
  logic e_busy  [N];
  logic e_done  [N];

  function automatic void build_frame(input int g, input logic [8:0] d);
    int   idx;
    logic par;
    for (int i = 0; i < 16; i++) m_bits[g][i] = 1'b1;
    idx = 0;
    par = 1'b0;
    m_bits[g][idx] = 1'b0;
    idx++;
    for (int i = 0; i < P_NB[g]; i++) begin
      m_bits[g][idx] = d[i];
      par = par ^ d[i];
      idx++;
    end
    if (P_PM[g] != 0) begin
      m_bits[g][idx] = (P_PM[g] == 2) ? ~par : par;
      idx++;
    end
    idx = idx + P_SB[g];
    m_total[g] = idx * NT;
  endfunction

  initial begin
    for (int g = 0; g < N; g++) begin
      m_act[g] = 1'b0; m_ticks[g] = 0; m_total[g] = 0;
      e_bit[g] = 1'b1; e_busy[g] = 1'b0; e_done[g] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int g = 0; g < N; g++) begin
        if (!rst_n) begin
          m_act[g] = 1'b0; e_bit[g] = 1'b1; e_busy[g] = 1'b0; e_done[g] = 1'b0;
        end else begin
          e_done[g] = 1'b0;
          if (!m_act[g]) begin
            if (tx_start[g]) begin
              build_frame(g, data_in[g]);
              m_act[g] = 1'b1; m_ticks[g] = 0;
              e_bit[g] = 1'b0; e_busy[g] = 1'b1;
            end else begin
              e_bit[g] = 1'b1; e_busy[g] = 1'b0;
            end
          end else if (tick) begin
            m_ticks[g] = m_ticks[g] + 1;
            if (m_ticks[g] == m_total[g]) begin
              m_act[g] = 1'b0; e_done[g] = 1'b1; e_busy[g] = 1'b0; e_bit[g] = 1'b1;
            end else begin
              e_bit[g] = m_bits[g][m_ticks[g] / NT];
            end
          end
        end
      end
    end
  end

  // Compare every DUT against the model each cycle, just after the edge.
  initial begin
    for (int g = 0; g < N; g++) done_cnt[g] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < N; g++) begin
        check($sformatf("u%0d_tx_bit", g),  32'(tx_bit[g]),  32'(e_bit[g]));
        check($sformatf("u%0d_tx_busy", g), 32'(tx_busy[g]), 32'(e_busy[g]));
        check($sformatf("u%0d_tx_done", g), 32'(tx_done[g]), 32'(e_done[g]));
        if (tx_done[g]) done_cnt[g] = done_cnt[g] + 1;
      end
    end
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < n * (tick_div + 1) + 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (tick) k++;
    end
    if (k < n) check("wait_ticks_timeout", 32'(k), 32'(n));
  endtask

  task automatic wait_done(input int g, input int limit);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tx_done[g] && n < limit);
    check($sformatf("u%0d_done_seen", g), 32'(tx_done[g]), 32'd1);
  endtask

  // Request, accept on the next edge, then scramble data_in to prove it is not re-read.
  task automatic start_frame(input int g, input logic [8:0] d);
    @(negedge clk);
    data_in[g]  = d;
    tx_start[g] = 1'b1;
    @(negedge clk);
    tx_start[g] = 1'b0;
    data_in[g]  = ~d;
  endtask

  logic exp_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int   d0;
    logic all_high;
    logic any_done;
    for (int g = 0; g < N; g++) begin
      tx_start[g] = 1'b0;
      data_in[g]  = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_tx_bit",  32'(tx_bit[0]),  32'd1);
    check("reset_tx_busy", 32'(tx_busy[0]), 32'd0);
    check("reset_tx_done", 32'(tx_done[0]), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5, tick every third clk: sample mid-bit.
    tick_div = 3;
    start_frame(0, 9'h0A5);
    check("a5_busy_after_accept", 32'(tx_busy[0]), 32'd1);
    wait_ticks(8);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("a5_bit%0d", i), 32'(tx_bit[0]), 32'(exp_a5[i]));
      if (i < 9) wait_ticks(16);
    end
    wait_ticks(7);
    check("a5_no_done_tick159", 32'(tx_done[0]), 32'd0);
    wait_ticks(1);
    check("a5_done_tick160", 32'(tx_done[0]), 32'd1);
    check("a5_busy_clear",   32'(tx_busy[0]), 32'd0);

    // Even and odd parity of 0x07 side by side.
    tick_div = 2;
    @(negedge clk);
    data_in[1] = 9'h007; data_in[2] = 9'h007;
    tx_start[1] = 1'b1;  tx_start[2] = 1'b1;
    @(negedge clk);
    tx_start[1] = 1'b0;  tx_start[2] = 1'b0;
    wait_ticks(152);
    check("even_parity_07", 32'(tx_bit[1]), 32'd1);
    check("odd_parity_07",  32'(tx_bit[2]), 32'd0);
    wait_ticks(23);
    check("odd_no_done_175", 32'(tx_done[2]), 32'd0);
    wait_ticks(1);
    check("odd_done_176",  32'(tx_done[2]), 32'd1);
    check("even_done_176", 32'(tx_done[1]), 32'd1);

    // 7 data bits, 2 stop bits, 0x55: 32 high ticks after the last data bit.
    tick_div = 1;
    start_frame(3, 9'h055);
    wait_ticks(128);
    all_high = tx_bit[3];
    any_done = tx_done[3];
    for (int k = 0; k < 31; k++) begin
      wait_ticks(1);
      all_high = all_high & tx_bit[3];
      any_done = any_done | tx_done[3];
    end
    check("stop2_line_high", 32'(all_high), 32'd1);
    check("stop2_no_early_done", 32'(any_done), 32'd0);
    wait_ticks(1);
    check("stop2_done_tick160", 32'(tx_done[3]), 32'd1);

    // Start request during a busy frame must be ignored.
    d0 = done_cnt[0];
    start_frame(0, 9'h000);
    wait_ticks(40);
    @(negedge clk);
    data_in[0] = 9'h0FF; tx_start[0] = 1'b1;
    @(negedge clk);
    tx_start[0] = 1'b0;
    wait_done(0, 400);
    repeat (20) @(negedge clk);
    check("ignored_start_idle", 32'(tx_busy[0]), 32'd0);
    check("ignored_start_one_done", 32'(done_cnt[0] - d0), 32'd1);

    // Reset at tick 70 aborts the frame without waiting for clk.
    start_frame(0, 9'h05A);
    wait_ticks(70);
    d0 = done_cnt[0];
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx_bit",  32'(tx_bit[0]),  32'd1);
    check("abort_tx_busy", 32'(tx_busy[0]), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
    start_frame(0, 9'h0C3);
    check("post_reset_accept", 32'(tx_busy[0]), 32'd1);
    wait_done(0, 400);

    // tx_start held high: back-to-back frames with one idle clk between them.
    @(negedge clk);
    d0 = done_cnt[0];
    data_in[0] = 9'h03C; tx_start[0] = 1'b1;
    @(negedge clk);
    data_in[0] = 9'h0C3;
    wait_done(0, 400);
    check("b2b_idle_gap", 32'(tx_busy[0]), 32'd0);
    @(posedge clk);
    #1;
    check("b2b_reaccept", 32'(tx_busy[0]), 32'd1);
    wait_done(0, 400);
    @(negedge clk);
    tx_start[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b_two_dones", 32'(done_cnt[0] - d0), 32'd2);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
